// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter sharing one memory/LSU port between fetch (m0) and load/store (m1).
// One transaction in flight at a time: latch in IDLE, issue, wait out read latency, respond.
module lsu_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_m0_req,
  input  logic              i_m0_wren,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  input  logic [2:0]        i_m0_funct3,
  output logic              o_m0_gnt,
  output logic              o_m0_rvalid,
  output logic [DATA_W-1:0] o_m0_rdata,
  input  logic              i_m1_req,
  input  logic              i_m1_wren,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  input  logic [2:0]        i_m1_funct3,
  output logic              o_m1_gnt,
  output logic              o_m1_rvalid,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wren,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [2:0]        o_mem_funct3,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy,
  output logic              o_owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [1:0]        cnt, cnt_nxt;
  logic              ptr, ptr_nxt;
  logic              take, sel_m1;

  logic              owner_p0;
  logic              wren_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [2:0]        funct3_p0;
  logic [DATA_W-1:0] m0_rdata_hold, m1_rdata_hold;

  // ptr=1 means m1 wins a tie; it always points at the requester not served last
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    take      = 1'b0;
    sel_m1    = 1'b0;
    case (state)
      IDLE: begin
        if (i_m0_req || i_m1_req) begin
          take      = 1'b1;
          sel_m1    = i_m1_req && (!i_m0_req || ptr);
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        ptr_nxt = ~owner_p0;
        if (wren_p0) begin
          state_nxt = IDLE;
        end else if (RD_LAT == 1) begin
          state_nxt = RESP;
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = 2'(RD_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt <= 2'd1) state_nxt = RESP;
        else             cnt_nxt   = cnt - 2'd1;
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // stage p0: accepted request fields and per-port read-data hold
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state         <= IDLE;
      cnt           <= 2'd0;
      ptr           <= 1'b1;
      owner_p0      <= 1'b0;
      wren_p0       <= 1'b0;
      addr_p0       <= '0;
      wdata_p0      <= '0;
      funct3_p0     <= 3'd0;
      m0_rdata_hold <= '0;
      m1_rdata_hold <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ptr   <= ptr_nxt;
      if (take) begin
        owner_p0  <= sel_m1;
        wren_p0   <= sel_m1 ? i_m1_wren   : i_m0_wren;
        addr_p0   <= sel_m1 ? i_m1_addr   : i_m0_addr;
        wdata_p0  <= sel_m1 ? i_m1_wdata  : i_m0_wdata;
        funct3_p0 <= sel_m1 ? i_m1_funct3 : i_m0_funct3;
      end
      if (state == RESP) begin
        if (owner_p0) m1_rdata_hold <= i_mem_rdata;
        else          m0_rdata_hold <= i_mem_rdata;
      end
    end
  end

  always_comb begin
    o_mem_addr   = addr_p0;
    o_mem_wdata  = wdata_p0;
    o_mem_funct3 = funct3_p0;
    o_mem_wren   = (state == ISSUE) && wren_p0;
    o_m0_gnt     = (state == ISSUE) && !owner_p0;
    o_m1_gnt     = (state == ISSUE) &&  owner_p0;
    o_m0_rvalid  = (state == RESP)  && !owner_p0;
    o_m1_rvalid  = (state == RESP)  &&  owner_p0;
    o_m0_rdata   = o_m0_rvalid ? i_mem_rdata : m0_rdata_hold;
    o_m1_rdata   = o_m1_rvalid ? i_mem_rdata : m1_rdata_hold;
    o_busy       = (state != IDLE);
    o_owner      = owner_p0;
  end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Bench for lsu_mem_arbiter with RD_LAT=2: a latency-exact memory model drives read data
// and expected transactions are queued at stimulus time, then popped when grants appear.
module tb_lsu_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_m0_req, i_m0_wren, i_m1_req, i_m1_wren;
  logic [ADDR_W-1:0] i_m0_addr, i_m1_addr;
  logic [DATA_W-1:0] i_m0_wdata, i_m1_wdata;
  logic [2:0]        i_m0_funct3, i_m1_funct3;
  logic              o_m0_gnt, o_m0_rvalid, o_m1_gnt, o_m1_rvalid;
  logic [DATA_W-1:0] o_m0_rdata, o_m1_rdata;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_wren;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [2:0]        o_mem_funct3;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              o_busy, o_owner;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        owner;
    logic        wren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
  } txn_t;
  txn_t exp_q[$];

  always #5 i_clk = ~i_clk;

  lsu_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_m0_req(i_m0_req), .i_m0_wren(i_m0_wren), .i_m0_addr(i_m0_addr),
    .i_m0_wdata(i_m0_wdata), .i_m0_funct3(i_m0_funct3),
    .o_m0_gnt(o_m0_gnt), .o_m0_rvalid(o_m0_rvalid), .o_m0_rdata(o_m0_rdata),
    .i_m1_req(i_m1_req), .i_m1_wren(i_m1_wren), .i_m1_addr(i_m1_addr),
    .i_m1_wdata(i_m1_wdata), .i_m1_funct3(i_m1_funct3),
    .o_m1_gnt(o_m1_gnt), .o_m1_rvalid(o_m1_rvalid), .o_m1_rdata(o_m1_rdata),
    .o_mem_addr(o_mem_addr), .o_mem_wren(o_mem_wren), .o_mem_wdata(o_mem_wdata),
    .o_mem_funct3(o_mem_funct3), .i_mem_rdata(i_mem_rdata),
    .o_busy(o_busy), .o_owner(o_owner)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h2008) ? 32'h1234_5678 : {a[15:0], ~a[15:0]};
  endfunction

  // Memory: data is valid only during the cycle RD_LAT edges after the issue cycle ends
  int          rd_cnt = 0;
  logic [31:0] rd_val = 32'h0;
  always @(posedge i_clk) begin
    if (rd_cnt > 0) rd_cnt <= rd_cnt - 1;
    if ((o_m0_gnt || o_m1_gnt) && !o_mem_wren) begin
      rd_cnt <= RD_LAT;
      rd_val <= mem_fn(o_mem_addr);
    end
  end
  assign i_mem_rdata = (rd_cnt == 1) ? rd_val : 32'hBAD0_BAD0;

  task automatic step();
    @(posedge i_clk); #1;
  endtask

  task automatic set_m0(input logic req, input logic wren, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3);
    i_m0_req = req; i_m0_wren = wren; i_m0_addr = addr; i_m0_wdata = wdata; i_m0_funct3 = f3;
  endtask

  task automatic set_m1(input logic req, input logic wren, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3);
    i_m1_req = req; i_m1_wren = wren; i_m1_addr = addr; i_m1_wdata = wdata; i_m1_funct3 = f3;
  endtask

  task automatic push(input logic owner, input logic wren, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] f3);
    txn_t t;
    t.owner = owner; t.wren = wren; t.addr = addr; t.wdata = wdata; t.f3 = f3;
    exp_q.push_back(t);
  endtask

  // Steps until a grant is visible; n = cycles taken, 0 if the budget expired
  task automatic wait_gnt(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (o_m0_gnt || o_m1_gnt) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    set_m0(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    exp_q.delete();
    i_rst = 1'b0;
    repeat (2) step();
    i_rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    set_m0(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    i_rst = 1'b0;
    step();
    tests++;
    if ({o_m0_gnt, o_m0_rvalid, o_m1_gnt, o_m1_rvalid, o_mem_wren, o_busy, o_owner} !== 7'd0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {o_m0_gnt, o_m0_rvalid, o_m1_gnt, o_m1_rvalid, o_mem_wren, o_busy, o_owner});
    end
    tests++;
    if ({o_mem_addr, o_mem_wdata, o_mem_funct3, o_m0_rdata, o_m1_rdata} !== '0) begin
      fails++;
      $display("FAIL reset_data: addr=%h wdata=%h f3=%b r0=%h r1=%h want all 0",
               o_mem_addr, o_mem_wdata, o_mem_funct3, o_m0_rdata, o_m1_rdata);
    end
    i_rst = 1'b1;
    step();
    tests++;
    if (o_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle_busy: got %b want 0", o_busy);
    end
  endtask

  task automatic test_write();
    txn_t e;
    int   n;
    set_m0(1'b1, 1'b1, 32'h2004, 32'hDEAD_BEEF, 3'b010);
    push(1'b0, 1'b1, 32'h2004, 32'hDEAD_BEEF, 3'b010);
    wait_gnt(n);
    i_m0_req = 1'b0;
    e = exp_q.pop_front();
    tests++;
    if (n !== 1 || o_m0_gnt !== 1'b1 || o_m1_gnt !== 1'b0) begin
      fails++;
      $display("FAIL wr_gnt: cycles=%0d gnt0=%b gnt1=%b want 1,1,0", n, o_m0_gnt, o_m1_gnt);
    end
    tests++;
    if (o_mem_wren !== e.wren || o_mem_addr !== e.addr || o_mem_wdata !== e.wdata ||
        o_mem_funct3 !== e.f3) begin
      fails++;
      $display("FAIL wr_issue: wren=%b addr=%h wdata=%h f3=%b want %b %h %h %b",
               o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_funct3, e.wren, e.addr, e.wdata, e.f3);
    end
    step();
    tests++;
    if (o_mem_wren !== 1'b0 || o_busy !== 1'b0 || o_m0_gnt !== 1'b0) begin
      fails++;
      $display("FAIL wr_after: wren=%b busy=%b gnt0=%b want 0 0 0", o_mem_wren, o_busy, o_m0_gnt);
    end
  endtask

  task automatic test_read_latency();
    txn_t e;
    int   n, lat;
    bit   m0_seen;
    set_m1(1'b1, 1'b0, 32'h2008, 32'h0, 3'b010);
    push(1'b1, 1'b0, 32'h2008, 32'h0, 3'b010);
    wait_gnt(n);
    i_m1_req = 1'b0;
    e = exp_q.pop_front();
    tests++;
    if (n == 0 || o_m1_gnt !== e.owner || o_mem_wren !== 1'b0 || o_mem_addr !== e.addr) begin
      fails++;
      $display("FAIL rd_issue: cycles=%0d gnt1=%b wren=%b addr=%h want gnt1=1 wren=0 addr=%h",
               n, o_m1_gnt, o_mem_wren, o_mem_addr, e.addr);
    end
    lat = 0;
    m0_seen = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (o_m0_rvalid) m0_seen = 1'b1;
      if (i == 1) begin
        tests++;
        if (o_mem_wren !== 1'b0 || o_busy !== 1'b1 || o_mem_addr !== e.addr) begin
          fails++;
          $display("FAIL rd_wait: wren=%b busy=%b addr=%h want 0 1 %h",
                   o_mem_wren, o_busy, o_mem_addr, e.addr);
        end
      end
      if (o_m1_rvalid) begin
        lat = i;
        break;
      end
    end
    tests++;
    if (lat !== RD_LAT) begin
      fails++;
      $display("FAIL rd_latency: got %0d want %0d", lat, RD_LAT);
    end
    tests++;
    if (o_m1_rdata !== mem_fn(e.addr)) begin
      fails++;
      $display("FAIL rd_data: got %h want %h", o_m1_rdata, mem_fn(e.addr));
    end
    step();
    tests++;
    if (o_m1_rvalid !== 1'b0 || m0_seen || o_m0_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL rd_single_pulse: rv1=%b rv0=%b m0_seen=%b want 0 0 0",
               o_m1_rvalid, o_m0_rvalid, m0_seen);
    end
    tests++;
    if (o_m1_rdata !== 32'h1234_5678 || o_m0_rdata !== 32'h0) begin
      fails++;
      $display("FAIL rd_hold: r1=%h r0=%h want 12345678 00000000", o_m1_rdata, o_m0_rdata);
    end
  endtask

  task automatic test_fairness();
    txn_t e;
    int   n;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      push(1'b1, 1'b1, 32'h200, 32'h1111_0000, 3'b010);
      push(1'b0, 1'b1, 32'h100, 32'h0000_2222, 3'b010);
    end
    set_m0(1'b1, 1'b1, 32'h100, 32'h0000_2222, 3'b010);
    set_m1(1'b1, 1'b1, 32'h200, 32'h1111_0000, 3'b010);
    for (int k = 0; k < 4; k++) begin
      wait_gnt(n);
      e = exp_q.pop_front();
      tests++;
      if (n == 0 || {o_m1_gnt, o_m0_gnt} !== {e.owner, ~e.owner} || o_mem_addr !== e.addr ||
          o_owner !== e.owner) begin
        fails++;
        $display("FAIL fair_grant%0d: cycles=%0d gnt1=%b gnt0=%b addr=%h owner=%b want owner=%b addr=%h",
                 k, n, o_m1_gnt, o_m0_gnt, o_mem_addr, o_owner, e.owner, e.addr);
      end
    end
    i_m0_req = 1'b0;
    i_m1_req = 1'b0;
    step();
  endtask

  task automatic test_wait_preempt();
    txn_t e;
    int   n;
    set_m1(1'b1, 1'b0, 32'h2040, 32'h0, 3'b010);
    push(1'b1, 1'b0, 32'h2040, 32'h0, 3'b010);
    push(1'b0, 1'b1, 32'h300, 32'h3333_3333, 3'b010);
    wait_gnt(n);
    e = exp_q.pop_front();
    tests++;
    if (n == 0 || o_m1_gnt !== e.owner) begin
      fails++;
      $display("FAIL preempt_first: cycles=%0d gnt1=%b want 1", n, o_m1_gnt);
    end
    step();
    set_m0(1'b1, 1'b1, 32'h300, 32'h3333_3333, 3'b010);
    wait_gnt(n);
    e = exp_q.pop_front();
    tests++;
    if (n == 0 || o_m0_gnt !== 1'b1 || o_m1_gnt !== 1'b0 || o_mem_addr !== e.addr) begin
      fails++;
      $display("FAIL preempt_next: cycles=%0d gnt0=%b gnt1=%b addr=%h want 1 0 %h",
               n, o_m0_gnt, o_m1_gnt, o_mem_addr, e.addr);
    end
    i_m0_req = 1'b0;
    i_m1_req = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_reset_mid();
    int n;
    bit rv_seen;
    set_m0(1'b1, 1'b0, 32'h2010, 32'h0, 3'b010);
    wait_gnt(n);
    i_m0_req = 1'b0;
    step();
    i_rst = 1'b0;
    #1;
    tests++;
    if ({o_m0_gnt, o_m0_rvalid, o_m1_gnt, o_m1_rvalid, o_mem_wren, o_busy, o_owner} !== 7'd0 ||
        {o_mem_addr, o_m0_rdata, o_m1_rdata} !== '0) begin
      fails++;
      $display("FAIL midrst_outputs: ctrl=%b addr=%h r0=%h r1=%h want all 0",
               {o_m0_gnt, o_m0_rvalid, o_m1_gnt, o_m1_rvalid, o_mem_wren, o_busy, o_owner},
               o_mem_addr, o_m0_rdata, o_m1_rdata);
    end
    step();
    i_rst = 1'b1;
    rv_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (o_m0_rvalid || o_m1_rvalid || o_busy) rv_seen = 1'b1;
    end
    tests++;
    if (rv_seen) begin
      fails++;
      $display("FAIL midrst_no_resp: got activity=1 want 0");
    end
    set_m0(1'b1, 1'b1, 32'h400, 32'h4, 3'b010);
    set_m1(1'b1, 1'b1, 32'h500, 32'h5, 3'b010);
    wait_gnt(n);
    i_m0_req = 1'b0;
    i_m1_req = 1'b0;
    tests++;
    if (n == 0 || o_m1_gnt !== 1'b1 || o_m0_gnt !== 1'b0) begin
      fails++;
      $display("FAIL midrst_ptr: cycles=%0d gnt1=%b gnt0=%b want 1 0", n, o_m1_gnt, o_m0_gnt);
    end
    step();
  endtask

  task automatic test_sb_funct3();
    txn_t e;
    int   n, lat;
    set_m0(1'b1, 1'b1, 32'h2003, 32'h0000_00AB, 3'b000);
    push(1'b0, 1'b1, 32'h2003, 32'h0000_00AB, 3'b000);
    wait_gnt(n);
    i_m0_req = 1'b0;
    e = exp_q.pop_front();
    tests++;
    if (n == 0 || o_m0_gnt !== 1'b1 || o_mem_funct3 !== e.f3 || o_mem_addr !== e.addr ||
        o_mem_wdata !== e.wdata || o_mem_wren !== 1'b1) begin
      fails++;
      $display("FAIL sb_issue: gnt0=%b f3=%b addr=%h wdata=%h wren=%b want 1 %b %h %h 1",
               o_m0_gnt, o_mem_funct3, o_mem_addr, o_mem_wdata, o_mem_wren, e.f3, e.addr, e.wdata);
    end
    step();
    tests++;
    if (o_mem_addr !== e.addr || o_mem_funct3 !== e.f3 || o_mem_wren !== 1'b0) begin
      fails++;
      $display("FAIL sb_idle_hold: addr=%h f3=%b wren=%b want %h %b 0",
               o_mem_addr, o_mem_funct3, o_mem_wren, e.addr, e.f3);
    end
    set_m0(1'b1, 1'b0, 32'h2003, 32'h0, 3'b100);
    push(1'b0, 1'b0, 32'h2003, 32'h0, 3'b100);
    wait_gnt(n);
    e = exp_q.pop_front();
    set_m0(1'b0, 1'b1, 32'hFFFF, 32'hFFFF_FFFF, 3'b111);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 1) begin
        tests++;
        if (o_mem_addr !== e.addr || o_mem_funct3 !== e.f3) begin
          fails++;
          $display("FAIL lbu_latched: addr=%h f3=%b want %h %b", o_mem_addr, o_mem_funct3, e.addr, e.f3);
        end
      end
      if (o_m0_rvalid) begin
        lat = i;
        break;
      end
    end
    tests++;
    if (lat !== RD_LAT || o_m0_rdata !== mem_fn(e.addr) || o_m1_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL lbu_resp: lat=%0d r0=%h rv1=%b want %0d %h 0",
               lat, o_m0_rdata, o_m1_rvalid, RD_LAT, mem_fn(e.addr));
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1;
    set_m0(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    #2;
    test_reset();
    test_write();
    test_read_latency();
    test_fairness();
    test_wait_preempt();
    test_reset_mid();
    test_sb_funct3();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
